// File: rtl/shift_add_mul_pkg.sv
// Shared definitions for the iterative arithmetic units (multiplier, divider, square root).
// Every unit uses the same accept / iterate / deliver handshake states.
package shift_add_mul_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mulstate_t;

endpackage

// File: rtl/shift_add_mul_if.sv
// Operand/product handshake bundle for the iterative multiplier.
// The master is the upstream/downstream environment; the slave is the multiplier.
interface shift_add_mul_if #(
    parameter int WIDTH = 8
);
    logic                   InValid;
    logic                   InReady;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   Flush;
    logic                   OutValid;
    logic                   OutReady;
    logic [2*WIDTH-1:0]     Product;

    modport master (
        output InValid, A, B, Flush, OutReady,
        input  InReady, OutValid, Product
    );

    modport slave (
        input  InValid, A, B, Flush, OutReady,
        output InReady, OutValid, Product
    );
endinterface

// File: rtl/shift_add_mul_adder.sv
// Generic unsigned ripple adder shared by the iterative arithmetic units.
// Callers zero-extend their operands so the carry lands in the top bit of y.
module adder #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-and-add multiplier: one partial-product add and
// right shift per cycle, WIDTH cycles per product, result held until consumed.
module shift_add_mul
    import shift_add_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_add_mul_if.slave    bus
);

    localparam int CW = $clog2(WIDTH + 1);

    mulstate_t          state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic [CW-1:0]      count_q, count_d;

    logic [WIDTH:0]     add_b;
    logic [WIDTH:0]     sum;

    // Hi[WIDTH] is always zero after each shift, so Hi is already the
    // zero-extended upper partial product the adder needs.
    assign add_b = {1'b0, mcand_q & {WIDTH{lo_q[0]}}};

    adder #(
        .WIDTH (WIDTH + 1)
    ) u_adder (
        .a (hi_q),
        .b (add_b),
        .y (sum)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        count_d = count_q;

        if (bus.Flush) begin
            // Abort wins over both handshakes: nothing captured, nothing delivered.
            state_d = MUL_IDLE;
        end else begin
            unique case (state_q)
                MUL_IDLE: begin
                    if (bus.InValid) begin
                        state_d = MUL_RUN;
                        mcand_d = bus.A;
                        lo_d    = bus.B;
                        hi_d    = '0;
                        count_d = '0;
                    end
                end
                MUL_RUN: begin
                    hi_d    = {1'b0, sum[WIDTH:1]};
                    lo_d    = {sum[0], lo_q[WIDTH-1:1]};
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (bus.OutReady) begin
                        state_d = MUL_IDLE;
                    end
                end
                default: begin
                    state_d = MUL_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MUL_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_d;
        end
    end

    assign bus.InReady  = (state_q == MUL_IDLE);
    assign bus.OutValid = (state_q == MUL_DONE);
    assign bus.Product  = {hi_q[WIDTH-1:0], lo_q};

endmodule

// File: doc/shift_add_mul.md
# shift_add_mul

Iterative unsigned shift-and-add multiplier: accepts two WIDTH-bit operands on a valid/ready handshake, produces a 2*WIDTH-bit product after WIDTH iteration cycles and holds it until consumed. Each iteration adds the multiplicand, or zero, into the running upper partial product, then shifts right. It is the sequential control and storage stage that feeds the generic `adder` and consumes its sum every cycle. It is intended for area-constrained configurations where a combinational multiplier is too large.

## Interface
- WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- InValid  in  1  operands present.
- InReady  out  1  block can accept operands.
- A  in  WIDTH  multiplicand, unsigned.
- B  in  WIDTH  multiplier, unsigned.
- Flush  in  1  synchronous abort; discards any operation in progress.
- OutValid  out  1  Product is valid.
- OutReady  in  1  consumer takes Product.
- Product  out  2*WIDTH  A*B, unsigned.

## Operation
- Registers:
  - Mcand (WIDTH bits).
  - Hi (WIDTH+1 bits).
  - Lo (WIDTH bits).
  - Count ($clog2(WIDTH+1) bits).
  - State.
- States:
  - IDLE: InReady=1.
  - RUN: iterating.
  - DONE: OutValid=1.
- IDLE -> RUN on InValid&InReady. At that edge: Mcand<=A, Lo<=B, Hi<=0, Count<=0.
- Each RUN cycle:
  - Sum = Hi[WIDTH-1:0] + (Lo[0] ? Mcand : 0), computed at WIDTH+1 bits with no carry lost.
  - {Hi,Lo} <= {1'b0, Sum, Lo[WIDTH-1:1]}, i.e. the concatenation {Sum,Lo} shifted right by one.
  - Count <= Count+1.
- RUN -> DONE on the edge where Count==WIDTH-1, which is the WIDTH-th iteration.
- Product = {Hi[WIDTH-1:0], Lo}. It is driven continuously from the registers.
- Product is only meaningful while OutValid=1. It is stable throughout DONE.
- DONE -> IDLE on OutValid&OutReady. Registers other than State are left unchanged.
- Flush=1 forces State<=IDLE on the next edge from any state:
  - Takes priority over every transition, including a coincident input or output handshake.
  - A coincident input handshake is not captured. InReady stays 1 in IDLE regardless of Flush, but the upstream stage must treat Flush as a discard.
  - A coincident output handshake is not counted as a delivery.
- InReady=1 only in IDLE. OutValid=1 only in DONE. There is no overlap of accept and deliver.
- The result is the exact unsigned product with no overflow. The maximum operand values give (2^WIDTH-1)^2, which fits in 2*WIDTH bits.

## Timing
- Reset (async assert, reset_n low) values:
  - State=IDLE, InReady=1, OutValid=0.
  - Product=0, with Hi, Lo, Mcand and Count all 0.
- Reset deassertion is synchronized externally. The first handshake is possible on the first edge with reset_n high.
- Latency: input handshake at edge E0 gives OutValid=1 after edge E0+WIDTH, i.e. WIDTH cycles.
- Back-pressure: OutValid and Product hold indefinitely while OutReady=0.
- Throughput: with OutReady tied high, accept E0, deliver at E0+WIDTH+1, InReady high after E0+WIDTH+1. The next accept is at E0+WIDTH+2 at the earliest.
- Reset mid-RUN or mid-DONE drops the operation immediately. No OutValid pulse follows.
- A or B changing during RUN has no effect; the operands are captured at acceptance only.
- Lo[0]=0 iterations still take a cycle. Latency does not depend on the data.

## Structure
- The shared package holds `typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mulstate_t`. Other iterative units (divider, square root) reuse the same handshake states.
- The counter width is a local parameter, CW = $clog2(WIDTH+1).
- There is one sub-module: the generic `adder` with WIDTH = WIDTH+1.
  - Operands: a = {1'b0, Hi[WIDTH-1:0]}, b = {1'b0, Mcand & {WIDTH{Lo[0]}}}.
  - Its output y is Sum.
- The FSM, counter and shift register are in this module. The single always_ff uses an asynchronous negedge reset_n.

## Test plan
- WIDTH=8, A=13, B=11, OutReady=1:
  - InReady drops on the edge after the handshake.
  - OutValid rises 8 cycles after acceptance with Product=16'h008F.
  - InReady returns one cycle later.
- A=8'hFF, B=8'hFF -> Product=16'hFE01. This is the max-carry case; Hi[8] is exercised.
- A=0, B=8'hA5 and A=8'h5A, B=0 -> Product=0, with latency still exactly 8 cycles.
- Back-pressure: OutReady=0 for 20 cycles after OutValid.
  - Product holds constant and InReady stays 0.
  - A single-cycle OutReady gives OutValid=0 next cycle.
- Flush at iteration 4, then accept A=3, B=7:
  - No OutValid for the flushed op.
  - The new op gives Product=21 after 8 cycles.
  - Flush coincident with InValid&InReady: no capture, state stays IDLE.
- reset_n low asynchronously mid-RUN:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, a new op A=2, B=200 gives Product=400.
